// File: rtl/fetch_ctrl.sv
// Fetch sequencer: req/ack instruction memory interface, one-entry skid buffer, redirect drain, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
  logic        load;
  logic [31:0] ld_instr, ld_pc;
  logic [31:0] target;

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d        = state_q;
    pc_f_d         = pc_f_q;
    req_addr_d     = req_addr_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    ifid_valid_d   = ifid_valid_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    load           = 1'b0;
    ld_instr       = imem_rdata;
    ld_pc          = pc_f_q;

    // Reset gates the request directly so it drops while rst is held low.
    imem_req  = rst & (state_q != HOLD);
    imem_addr = (state_q == DRAIN) ? req_addr_q : pc_f_q;

    if (redirect_valid) begin
      pc_f_d       = target;
      ifid_valid_d = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      state_d      = REQ;
      // An unacknowledged request must complete before the new path is fetched.
      if (state_q != HOLD && !imem_ack) begin
        state_d    = DRAIN;
        req_addr_d = imem_addr;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (imem_ack) begin
            pc_f_d = pc_f_q + PC_INC;
            if (!ifid_valid_q || !stall_d) begin
              load = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_f_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            load     = 1'b1;
            ld_instr = skid_instr_q;
            ld_pc    = skid_pc_q;
            state_d  = REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) state_d = REQ;
        end
        default: state_d = REQ;
      endcase

      if (load) begin
        ifid_valid_d   = 1'b1;
        ifid_instr_d   = ld_instr;
        ifid_pc_d      = ld_pc;
        ifid_pcplus4_d = ld_pc + PC_INC;
      end else if (!stall_d) begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= REQ;
      pc_f_q         <= RESET_PC;
      req_addr_q     <= '0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= '0;
      ifid_pc_q      <= '0;
      ifid_pcplus4_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_f_q         <= pc_f_d;
      req_addr_q     <= req_addr_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
    end
  end

  assign valid_d   = ifid_valid_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pcplus4_d = ifid_pcplus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'b0, load & ~redirect_valid};
    perf_stall_d   = perf_stall_q + {31'b0, ifid_valid_q & stall_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: transaction-level fetch model plus directed literal checks.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        req;
  logic [31:0] addr;
  logic        vd;
  logic [31:0] id, pd, p4d;

  logic        req2, vd2;
  logic [31:0] addr2, id2, pd2, p4d2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf, ps, pf2, ps2;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_valid(redir), .redirect_pc(rpc), .stall_d(stall),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .valid_d(vd), .instr_d(id), .pc_d(pd), .pcplus4_d(p4d)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pf), .perf_stall(ps)
`endif
  );

  fetch_ctrl #(.RESET_PC(32'hFFFFFFFC), .PC_INC(32'd4)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0), .stall_d(1'b0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_rdata(32'h00000013),
    .valid_d(vd2), .instr_d(id2), .pc_d(pd2), .pcplus4_d(p4d2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pf2), .perf_stall(ps2)
`endif
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hFFC4A303;
      32'h4:   return 32'h00832383;
      32'h8:   return 32'h00736233;
      default: return a ^ 32'h5A5A0013;
    endcase
  endfunction

  // Transaction-level model: next fetch address, outstanding wrong-path request, skid slot, IF/ID contents.
  logic [31:0] m_pc, m_daddr, m_sk_i, m_sk_pc, m_i, m_p, m_p4;
  logic        m_drain, m_skid, m_v;
  int unsigned m_fetched, m_stalls, wcnt;
  int unsigned lat = 0;
  bit          tied = 1'b1;
  bit          chk_en = 1'b0;

  function automatic logic m_req();
    return !m_skid;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_daddr : m_pc;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_drain = 0; m_daddr = '0; m_skid = 0; m_sk_i = '0; m_sk_pc = '0;
    m_v = 0; m_i = '0; m_p = '0; m_p4 = '0; m_fetched = 0; m_stalls = 0; wcnt = 0;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] pc);
    m_v = 1; m_i = ins; m_p = pc; m_p4 = pc + 32'd4; m_fetched++;
  endtask

  task automatic model_step();
    logic        req0, ack0;
    logic [31:0] addr0;
    req0 = m_req(); addr0 = m_addr(); ack0 = ack;
    if (m_v && stall) m_stalls++;
    if (redir) begin
      if (req0 && !ack0) begin m_daddr = addr0; m_drain = 1; end
      else m_drain = 0;
      m_pc = rpc & ~32'd3; m_skid = 0; m_v = 0;
    end else if (m_skid) begin
      if (!stall) begin put(m_sk_i, m_sk_pc); m_skid = 0; end
    end else if (ack0 && m_drain) begin
      m_drain = 0;
      if (!stall) m_v = 0;
    end else if (ack0) begin
      if (!m_v || !stall) put(rdata, m_pc);
      else begin m_skid = 1; m_sk_i = rdata; m_sk_pc = m_pc; end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_v = 0;
    end
    wcnt = (m_req() && req0 && !ack0 && m_addr() == addr0) ? wcnt + 1 : 0;
  endtask

  task automatic apply_inputs();
    ack   = tied ? 1'b1 : (m_req() && wcnt >= lat);
    rdata = (ack && m_req()) ? mem(m_addr()) : 32'hDEADBEEF;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    apply_inputs();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {31'b0, req}, {31'b0, m_req()});
      if (m_req()) check("imem_addr", addr, m_addr());
      check("valid_d", {31'b0, vd}, {31'b0, m_v});
      if (m_v) begin
        check("instr_d", id, m_i);
        check("pc_d", pd, m_p);
        check("pcplus4_d", p4d, m_p4);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", pf, m_fetched);
      check("perf_stall", ps, m_stalls);
`endif
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_valid", {31'b0, vd}, 32'd0);
    check("rst_instr", id, 32'd0);
    check("rst_pc", pd, 32'd0);
    check("rst_pcplus4", p4d, 32'd0);
    check("rst_req2", {31'b0, req2}, 32'd0);

    rst = 1'b1;
    apply_inputs();
    chk_en = 1'b1;

    // Back-to-back zero-wait fetches; second instance wraps from 0xFFFFFFFC.
    step();
    check("t1_pc0", pd, 32'h0);
    check("t1_ins0", id, 32'hFFC4A303);
    check("t1_p4_0", p4d, 32'h4);
    check("t6_pc", pd2, 32'hFFFFFFFC);
    check("t6_p4", p4d2, 32'h0);
    check("t6_addr", addr2, 32'h0);
    step();
    check("t1_pc1", pd, 32'h4);
    check("t1_ins1", id, 32'h00832383);
    check("t6_pc_wrap", pd2, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_perf", pf2, 32'd2);
`endif
    step();
    check("t1_pc2", pd, 32'h8);
    check("t1_ins2", id, 32'h00736233);
    check("t1_p4_2", p4d, 32'hC);

    // Stall for 4 cycles while 0xC returns into the skid buffer.
    stall = 1'b1; apply_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold_pc", pd, 32'h8);
      check("t3_req_off", {31'b0, req}, 32'd0);
    end
    stall = 1'b0; apply_inputs();
    step();
    check("t3_pc_c", pd, 32'hC);
    step();
    check("t3_pc_10", pd, 32'h10);

    // Three-cycle ack latency on 0x14.
    tied = 1'b0; lat = 3; apply_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_addr", addr, 32'h14);
      check("t2_valid", {31'b0, vd}, 32'd0);
    end
    step();
    check("t2_pc", pd, 32'h14);
    check("t2_valid1", {31'b0, vd}, 32'd1);

    // Redirect while 0x18 has been pending two cycles.
    step(); step();
    redir = 1'b1; rpc = 32'h100; apply_inputs();
    step();
    redir = 1'b0; apply_inputs();
    check("t4_drain_addr", addr, 32'h18);
    check("t4_valid", {31'b0, vd}, 32'd0);
    step();
    check("t4_new_addr", addr, 32'h100);
    check("t4_valid2", {31'b0, vd}, 32'd0);
    repeat (4) step();
    check("t4_pc", pd, 32'h100);

    // Redirect coinciding with ack and stall.
    lat = 0; stall = 1'b1; redir = 1'b1; rpc = 32'h203; apply_inputs();
    step();
    check("t5_valid", {31'b0, vd}, 32'd0);
    check("t5_addr", addr, 32'h200);
    redir = 1'b0; stall = 1'b0; apply_inputs();
    step();
    check("t5_pc", pd, 32'h200);

    // Mixed stalls, latencies and redirects (including in HOLD and repeated in DRAIN).
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 11) == 0);
      rpc   = {22'b0, $urandom_range(0, 255), $urandom_range(0, 3)};
      if (i % 37 == 0) lat = $urandom_range(0, 3);
      apply_inputs();
      step();
    end
    redir = 1'b0; stall = 1'b0; apply_inputs();
    step();

    // Reset asserted mid-cycle drops the request immediately.
    chk_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, req}, 32'd0);
    check("mid_rst_valid", {31'b0, vd}, 32'd0);
    check("mid_rst_pc", pd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
